// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, DATA_BITS data bits, optional parity, 1 or 2 stop bits.
// Bit timing is derived from a shared OVERSAMPLE-times-baud tick; tx is registered.
module uart_frame_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy,
    output logic                 done_tick
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   bit_wrap;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        tx_d     = 1'b1;
        bit_wrap = baud_tick && (tick_q == TICK_LAST);

        if (state_q != S_IDLE && baud_tick) begin
            tick_d = bit_wrap ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    shreg_d  = data_in;
                    parity_d = (PARITY == 2) ? ~(^data_in) : ^data_in;
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_wrap) begin
                    shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_wrap) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the next state so tx changes in the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = (MSB_FIRST != 0) ? shreg_d[DATA_BITS-1] : shreg_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign ready_out = (state_q == S_IDLE);
    assign busy      = ~ready_out;
    assign tx        = tx_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: five configurations, frames checked bit period by bit period
// against hand-written expected line sequences ("0" = low, "1" = high, start bit first).
module tb_uart_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [5];
    logic       tick_v  [5];
    logic       valid_v [5];
    logic [7:0] data_v  [5];
    logic       ready_v [5];
    logic       tx_v    [5];
    logic       busy_v  [5];
    logic       done_v  [5];

    int tests = 0;
    int fails = 0;

    // 0: 8N1 MSB first, 1: 8E1, 2: 8O1, 3: 7N2 LSB first, 4: 8N1 with OVERSAMPLE=2
    uart_frame_tx u_8n1 (
        .clk(clk), .reset(rst_v[0]), .baud_tick(tick_v[0]), .data_in(data_v[0]),
        .valid_in(valid_v[0]), .ready_out(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
        .done_tick(done_v[0])
    );
    uart_frame_tx #(.PARITY(1)) u_8e1 (
        .clk(clk), .reset(rst_v[1]), .baud_tick(tick_v[1]), .data_in(data_v[1]),
        .valid_in(valid_v[1]), .ready_out(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
        .done_tick(done_v[1])
    );
    uart_frame_tx #(.PARITY(2)) u_8o1 (
        .clk(clk), .reset(rst_v[2]), .baud_tick(tick_v[2]), .data_in(data_v[2]),
        .valid_in(valid_v[2]), .ready_out(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
        .done_tick(done_v[2])
    );
    uart_frame_tx #(.DATA_BITS(7), .STOP_BITS(2), .MSB_FIRST(0)) u_7n2_lsb (
        .clk(clk), .reset(rst_v[3]), .baud_tick(tick_v[3]), .data_in(data_v[3][6:0]),
        .valid_in(valid_v[3]), .ready_out(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]),
        .done_tick(done_v[3])
    );
    uart_frame_tx #(.OVERSAMPLE(2)) u_os2 (
        .clk(clk), .reset(rst_v[4]), .baud_tick(tick_v[4]), .data_in(data_v[4]),
        .valid_in(valid_v[4]), .ready_out(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]),
        .done_tick(done_v[4])
    );

    // Called at a negedge with the instance idle. Offers `word`, then walks the frame, giving one
    // baud tick every `period` clocks. With hold=1, valid stays high carrying next_word so the
    // following frame is accepted in the done cycle; the task then returns at that done negedge.
    task automatic frame(input int idx, input logic [7:0] word, input string exp, input int os,
                         input int period, input bit hold, input logic [7:0] next_word,
                         input string name);
        int   nb, cnt, bit_i, ph, limit;
        bit   bad, ctl_bad, finished, want;
        logic got;
        nb = exp.len();
        cnt = 0; bit_i = 0; ph = 0; bad = 0; ctl_bad = 0; finished = 0; got = 1'b0;
        limit = os * nb * period + 8;
        data_v[idx]  = word;
        valid_v[idx] = 1'b1;
        tick_v[idx]  = 1'b1;
        @(negedge clk);
        tests++;
        if (ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: ready=%b busy=%b, required ready=0 busy=1",
                     name, ready_v[idx], busy_v[idx]);
        end
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            want = (exp[bit_i] == 8'h31);
            if (tx_v[idx] !== want) begin
                bad = 1'b1;
                got = tx_v[idx];
            end
            if (ready_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) ctl_bad = 1'b1;
            if (cyc % 7 == 3 && cyc < limit / 2) begin
                valid_v[idx] = 1'b1;
                data_v[idx]  = 8'hEE;
            end else begin
                valid_v[idx] = hold;
                data_v[idx]  = hold ? next_word : ~word;
            end
            tick_v[idx] = (ph == 0);
            ph = (ph + 1 == period) ? 0 : ph + 1;
            if (tick_v[idx]) begin
                cnt++;
                if (cnt == os) begin
                    cnt = 0;
                    tests++;
                    if (bad) begin
                        fails++;
                        $display("FAIL %s bit %0d: tx=%b, required %b", name, bit_i, got, want);
                    end
                    bad = 1'b0;
                    bit_i++;
                    if (bit_i == nb) finished = 1'b1;
                end
            end
            @(negedge clk);
        end
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s timeout: frame walk did not complete within %0d cycles", name, limit);
        end else if (done_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1 || tx_v[idx] !== 1'b1) begin
            fails++;
            $display("FAIL %s done: done=%b ready=%b tx=%b, required 1 1 1",
                     name, done_v[idx], ready_v[idx], tx_v[idx]);
        end
        tests++;
        if (ctl_bad) begin
            fails++;
            $display("FAIL %s in-frame: ready/done=1 seen mid-frame, required 0/0", name);
        end
        valid_v[idx] = hold;
        data_v[idx]  = next_word;
        tick_v[idx]  = 1'b0;
        if (!hold) begin
            @(negedge clk);
            tests++;
            if (done_v[idx] !== 1'b0 || ready_v[idx] !== 1'b1 || tx_v[idx] !== 1'b1) begin
                fails++;
                $display("FAIL %s after-done: done=%b ready=%b tx=%b, required 0 1 1",
                         name, done_v[idx], ready_v[idx], tx_v[idx]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            rst_v[i] = 1'b1; tick_v[i] = 1'b0; valid_v[i] = 1'b0; data_v[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (tx_v[i] !== 1'b1 || ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset inst%0d: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                         i, tx_v[i], ready_v[i], busy_v[i], done_v[i]);
            end
            rst_v[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_idle_ticks();
        bit bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick_v[0] = 1'b1;
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) bad = 1'b1;
        end
        tick_v[0] = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL idle_ticks: line left idle under baud ticks, required tx=1 ready=1 done=0");
        end
    endtask

    task automatic test_8n1();
        frame(0, 8'hA5, "0101001011", 16, 3, 1'b0, 8'h00, "8n1_a5");
    endtask

    task automatic test_parity();
        frame(1, 8'h07, "00000011111", 16, 2, 1'b0, 8'h00, "even_07");
        frame(2, 8'h07, "00000011101", 16, 2, 1'b0, 8'h00, "odd_07");
    endtask

    task automatic test_lsb_7n2();
        frame(3, 8'h41, "0100000111", 16, 2, 1'b0, 8'h00, "lsb7n2_41");
    endtask

    task automatic test_back_to_back();
        frame(0, 8'h12, "0000100101", 16, 2, 1'b1, 8'h34, "b2b_12");
        frame(0, 8'h34, "0001101001", 16, 2, 1'b0, 8'h00, "b2b_34");
    endtask

    task automatic test_reset_mid();
        int  ticks = 0;
        int  ph = 0;
        bit  bad = 1'b0;
        data_v[0] = 8'hFF; valid_v[0] = 1'b1; tick_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        for (int c = 0; c < 400 && ticks < 70; c++) begin
            tick_v[0] = (ph == 0);
            ph = (ph == 2) ? 0 : ph + 1;
            if (tick_v[0]) ticks++;
            @(negedge clk);
        end
        tests++;
        if (ready_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid pre: ready=%b after %0d ticks, required 0", ready_v[0], ticks);
        end
        rst_v[0] = 1'b1; tick_v[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid edge: tx=%b ready=%b done=%b, required 1 1 0",
                     tx_v[0], ready_v[0], done_v[0]);
        end
        rst_v[0] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick_v[0] = (c % 3 == 0);
            @(negedge clk);
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad = 1'b1;
        end
        tick_v[0] = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_mid abandon: done or low tx seen after reset, required done=0 tx=1");
        end
        frame(0, 8'h00, "0000000001", 16, 3, 1'b0, 8'h00, "after_reset_00");
    endtask

    task automatic test_const_tick();
        frame(4, 8'h80, "0100000001", 2, 1, 1'b0, 8'h00, "os2_80");
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_8n1();
        test_parity();
        test_lsb_7n2();
        test_back_to_back();
        test_reset_mid();
        test_const_tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART frame transmitter driven by the shared 16x-oversample baud tick from `BaudRateGenerator`. It accepts a data word over a valid/ready handshake and serialises it onto `tx` as start bit, data bits, optional parity and 1 or 2 stop bits. Bit order is selectable. It is the transmit half of `Main` and produces the same frames the bench drives into `rx`.

## Interface
- `DATA_BITS`, 8: data word width; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `OVERSAMPLE`, 16: baud ticks per bit period; legal range ≥2.
- `MSB_FIRST`, 1: 1 = data MSB sent first (codebase frame convention); 0 = LSB first.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `baud_tick` in 1: one-`clk` pulse at OVERSAMPLE × baud rate.
- `data_in` in DATA_BITS: word to send; sampled on accept.
- `valid_in` in 1: `data_in` is valid.
- `ready_out` out 1: block can accept a word.
- `tx` out 1: serial line, registered; idles high.
- `busy` out 1: frame in progress.
- `done_tick` out 1: one-`clk` pulse at frame end.

## Operation
- Reset values: `tx`=1, `ready_out`=1, `busy`=0, `done_tick`=0. State is IDLE, and all counters and shift registers are 0.
- States: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
- **Accept:** occurs when `valid_in && ready_out` in IDLE. On accept:
  - latch `data_in` into the shift register;
  - compute the parity bit from the latched word (even: XOR of bits; odd: inverted XOR);
  - clear the tick counter and bit counter;
  - go to START.
- **`ready_out`** = (state == IDLE). It is combinational from the state register.
- **`busy`** = !`ready_out`.
- **Bit periods:** each bit is held on `tx` for exactly OVERSAMPLE `baud_tick` pulses. The tick counter is `$clog2(OVERSAMPLE)` bits wide, increments on `baud_tick`, and wraps to 0 on the OVERSAMPLE-th tick. The bit advances on that wrap.
- **START:** `tx`=0.
- **DATA:** `tx` = current data bit.
  - MSB_FIRST=1: send `shreg[DATA_BITS-1]`, shift left each bit.
  - MSB_FIRST=0: send `shreg[0]`, shift right each bit.
  - Leave after DATA_BITS bits.
- **PARITY:** `tx` = parity bit, one bit period.
- **STOP:** `tx`=1 for STOP_BITS periods.
- **Frame end:** on the final wrap of the last stop bit, `done_tick`=1 for that one cycle and the state returns to IDLE.
- **Total frame length:** OVERSAMPLE × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) ticks.
- **Ignored inputs:**
  - `valid_in` while busy is ignored; the word is not latched.
  - `data_in` changes after accept have no effect.
  - `baud_tick` in IDLE is ignored.

## Timing
- Accept at cycle N means `tx` goes 0 at cycle N+1, because `tx` is registered from the next state.
- A `baud_tick` in the accept cycle N is not counted. Counting starts at N+1.
- The state returns to IDLE in the cycle after the last tick. `done_tick` is high in that same cycle, and `ready_out` is 1 in that cycle.
- **Back-to-back:** if `valid_in` is high when `ready_out` rises, the next frame is accepted immediately. The next start bit follows the stop bit(s) with one `clk` of `tx`=1 gap and zero extra bit periods.
- **Reset mid-frame:** the state returns to IDLE, `tx`=1 on the next edge, and the frame is abandoned. No `done_tick` is produced.
- `baud_tick` held high every cycle is legal: each bit then lasts OVERSAMPLE `clk` cycles.

## Test plan
- **8N1, MSB first, 0xA5:** `tx` = 0,1,0,1,0,0,1,0,1,1, each for 16 ticks. `done_tick` fires once after 160 ticks. `ready_out` is 0 throughout the frame.
- **PARITY=1 (even), 0x07, MSB first:** data 0,0,0,0,0,1,1,1, then parity bit 1, then stop 1. With PARITY=2 and the same word, the parity bit is 0. Frame is 176 ticks.
- **MSB_FIRST=0, DATA_BITS=7, STOP_BITS=2, word 0x41:** data 1,0,0,0,0,0,1, then stop bits 1,1. Frame is 160 ticks.
- **Back-to-back 0x12 then 0x34, `valid_in` held:** two complete frames. The second start bit begins one `clk` after the first `done_tick`. `valid_in` pulses during frame 1 with other data do not alter either frame.
- **Reset asserted at tick 70 of a 0xFF frame:** `tx`=1 and `ready_out`=1 on the next edge. No `done_tick`. A new 0x00 frame then sends correctly.
- **`baud_tick`=1 constantly, OVERSAMPLE=2, 0x80:** each bit lasts 2 `clk` cycles. `tx` low at N+1, high over N+3..N+4 (MSB).
